// File: rtl/sy_ppl_lsu_mmu_arb_pkg.sv
// Shared types for the LSU-to-MMU translation arbiter: exception record and arbiter state.
package sy_pkg;

    typedef struct packed {
        logic        valid;
        logic [63:0] cause;
        logic [63:0] tval;
    } excp_t;

    typedef enum logic {
        MMU_ARB_IDLE = 1'b0,
        MMU_ARB_BUSY = 1'b1
    } mmu_arb_state_e;

endpackage

// File: rtl/sy_ppl_lsu_mmu_arb_if.sv
// Requester and MMU signals of the translation arbiter; the master modport is the arbiter side.
interface sy_ppl_lsu_mmu_arb_if
    import sy_pkg::*;
#(
    parameter int N_REQ = 2
);
    logic                   flush_i;
    logic [N_REQ-1:0]       req_i;
    logic [N_REQ-1:0][63:0] vaddr_i;
    logic [N_REQ-1:0]       is_store_i;
    logic [N_REQ-1:0]       gnt_o;
    logic [N_REQ-1:0]       hit_o;
    logic [N_REQ-1:0]       valid_o;
    logic [63:0]            paddr_o;
    excp_t                  ex_o;

    logic                   lsu_mmu__req_o;
    logic [63:0]            lsu_mmu__vaddr_o;
    logic                   lsu_mmu__is_store_o;
    logic                   mmu_lsu__hit_i;
    logic                   mmu_lsu__valid_i;
    logic [63:0]            mmu_lsu__paddr_i;
    excp_t                  mmu_lsu__ex_i;

    modport master (
        input  flush_i, req_i, vaddr_i, is_store_i,
        input  mmu_lsu__hit_i, mmu_lsu__valid_i, mmu_lsu__paddr_i, mmu_lsu__ex_i,
        output gnt_o, hit_o, valid_o, paddr_o, ex_o,
        output lsu_mmu__req_o, lsu_mmu__vaddr_o, lsu_mmu__is_store_o
    );

    modport slave (
        output flush_i, req_i, vaddr_i, is_store_i,
        output mmu_lsu__hit_i, mmu_lsu__valid_i, mmu_lsu__paddr_i, mmu_lsu__ex_i,
        input  gnt_o, hit_o, valid_o, paddr_o, ex_o,
        input  lsu_mmu__req_o, lsu_mmu__vaddr_o, lsu_mmu__is_store_o
    );

endinterface

// File: rtl/sy_ppl_lsu_rr_pick.sv
// Combinational N-way picker: first requesting index at or after ptr, wrapping modulo N_REQ.
module sy_ppl_lsu_rr_pick #(
    parameter int N_REQ   = 2,
    parameter int REQ_WTH = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0]   req,
    input  logic [REQ_WTH-1:0] ptr,
    output logic [N_REQ-1:0]   gnt,
    output logic [REQ_WTH-1:0] idx,
    output logic               any
);

    logic [REQ_WTH-1:0] cand;

    // Walk offsets from the far end down so the smallest offset from ptr wins last.
    always_comb begin
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        cand = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            cand = REQ_WTH'((int'(ptr) + i) % N_REQ);
            if (req[cand]) begin
                gnt       = '0;
                gnt[cand] = 1'b1;
                idx       = cand;
                any       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sy_ppl_lsu_mmu_arb.sv
// Shares the data-side MMU port among N_REQ LSU requesters and locks it across a page walk.
// SY_MMU_ARB_RR_EN selects round-robin arbitration; otherwise the lowest index wins.
module sy_ppl_lsu_mmu_arb
    import sy_pkg::*;
#(
    parameter int N_REQ   = 2,
    parameter int REQ_WTH = $clog2(N_REQ)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    sy_ppl_lsu_mmu_arb_if.master bus
);

    mmu_arb_state_e     state_q;
    logic [REQ_WTH-1:0] owner_q;
    logic [REQ_WTH-1:0] rr_ptr_q;
    logic [N_REQ-1:0]   win_oh;
    logic [REQ_WTH-1:0] win_idx;
    logic               win_any;
    logic [REQ_WTH-1:0] sel;
    logic               blk;

    sy_ppl_lsu_rr_pick #(
        .N_REQ   (N_REQ),
        .REQ_WTH (REQ_WTH)
    ) u_pick (
        .req (bus.req_i),
        .ptr (rr_ptr_q),
        .gnt (win_oh),
        .idx (win_idx),
        .any (win_any)
    );

    // Nothing is granted while flushing or held in reset, even with requests pending.
    assign blk = bus.flush_i | rst_i;

    always_comb begin
        sel                 = win_idx;
        bus.gnt_o           = '0;
        bus.hit_o           = '0;
        bus.valid_o         = '0;
        bus.lsu_mmu__req_o  = 1'b0;
        if (state_q == MMU_ARB_BUSY) begin
            sel = owner_q;
            if (!blk) begin
                bus.gnt_o[owner_q] = 1'b1;
                bus.lsu_mmu__req_o = bus.req_i[owner_q];
                if (bus.mmu_lsu__valid_i) begin
                    bus.valid_o[owner_q] = 1'b1;
                end
            end
        end else if (!blk && win_any) begin
            bus.gnt_o          = win_oh;
            bus.lsu_mmu__req_o = 1'b1;
            if (bus.mmu_lsu__hit_i) begin
                bus.hit_o = win_oh;
            end
        end
    end

    assign bus.lsu_mmu__vaddr_o    = bus.vaddr_i[sel];
    assign bus.lsu_mmu__is_store_o = bus.is_store_i[sel];
    assign bus.paddr_o             = bus.mmu_lsu__paddr_i;
    assign bus.ex_o                = bus.mmu_lsu__ex_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= MMU_ARB_IDLE;
            owner_q <= '0;
        end else if (bus.flush_i) begin
            state_q <= MMU_ARB_IDLE;
        end else begin
            case (state_q)
                MMU_ARB_IDLE: begin
                    if (win_any && !bus.mmu_lsu__hit_i) begin
                        owner_q <= win_idx;
                        state_q <= MMU_ARB_BUSY;
                    end
                end
                MMU_ARB_BUSY: begin
                    if (bus.mmu_lsu__valid_i || !bus.req_i[owner_q]) begin
                        state_q <= MMU_ARB_IDLE;
                    end
                end
            endcase
        end
    end

`ifdef SY_MMU_ARB_RR_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_ptr_q <= '0;
        end else if (!bus.flush_i && state_q == MMU_ARB_IDLE && win_any) begin
            rr_ptr_q <= (win_idx == REQ_WTH'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
        end
    end
`else
    assign rr_ptr_q = '0;
`endif

endmodule

// File: tb/tb_sy_ppl_lsu_mmu_arb.sv
// Directed self-checking bench for sy_ppl_lsu_mmu_arb with two requesters.
module tb_sy_ppl_lsu_mmu_arb;
    import sy_pkg::*;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_fail;

    sy_ppl_lsu_mmu_arb_if #(.N_REQ(2)) bus ();

    sy_ppl_lsu_mmu_arb #(.N_REQ(2)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] req, input logic hit, input logic vld, input logic fl);
        bus.req_i            = req;
        bus.mmu_lsu__hit_i   = hit;
        bus.mmu_lsu__valid_i = vld;
        bus.flush_i          = fl;
    endtask

    initial begin
        logic [1:0] exp_g;
        excp_t      ex_in;
        n_chk  = 0;
        n_fail = 0;
        rst    = 1'b1;
        drive(2'b00, 1'b0, 1'b0, 1'b0);
        bus.vaddr_i[0]        = 64'h0000_1234;
        bus.vaddr_i[1]        = 64'h0000_5678;
        bus.is_store_i        = 2'b01;
        bus.mmu_lsu__paddr_i  = 64'h0;
        bus.mmu_lsu__ex_i     = '0;

        // reset state
        settle();
        chk("rst_req",   64'(bus.lsu_mmu__req_o), 64'd0);
        chk("rst_gnt",   64'(bus.gnt_o), 64'd0);
        chk("rst_hit",   64'(bus.hit_o), 64'd0);
        chk("rst_vld",   64'(bus.valid_o), 64'd0);
        chk("rst_vaddr", bus.lsu_mmu__vaddr_o, 64'h0000_1234);
        chk("rst_store", 64'(bus.lsu_mmu__is_store_o), 64'd1);
        adv();
        rst = 1'b0;

        // single hit
        bus.vaddr_i[0] = 64'h8000_1000;
        bus.mmu_lsu__paddr_i = 64'h0000_0000_4000_1000;
        ex_in = '{valid: 1'b1, cause: 64'd13, tval: 64'h8000_1000};
        bus.mmu_lsu__ex_i = ex_in;
        drive(2'b01, 1'b1, 1'b0, 1'b0);
        settle();
        chk("hit_gnt",   64'(bus.gnt_o), 64'b01);
        chk("hit_hit",   64'(bus.hit_o), 64'b01);
        chk("hit_req",   64'(bus.lsu_mmu__req_o), 64'd1);
        chk("hit_vaddr", bus.lsu_mmu__vaddr_o, 64'h8000_1000);
        chk("hit_paddr", bus.paddr_o, 64'h4000_1000);
        chk("hit_excause", bus.ex_o.cause, 64'd13);
        adv();
        drive(2'b00, 1'b0, 1'b0, 1'b0);
        bus.mmu_lsu__ex_i = '0;
        settle();
        chk("hit_idle_gnt", 64'(bus.gnt_o), 64'd0);
        adv();

        // conflict: both requesters hit every cycle, starting from a fresh pointer
        rst = 1'b1;
        #1;
        rst = 1'b0;
        drive(2'b11, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
`ifdef SY_MMU_ARB_RR_EN
            exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
`else
            exp_g = 2'b01;
`endif
            settle();
            chk("arb_gnt", 64'(bus.gnt_o), 64'(exp_g));
            chk("arb_hit", 64'(bus.hit_o), 64'(exp_g));
            adv();
        end

        // miss lock: requester 1 misses, requester 0 joins, valid on the fifth cycle
        bus.vaddr_i[0] = 64'h8000_1000;
        bus.vaddr_i[1] = 64'h9000_2000;
        drive(2'b10, 1'b0, 1'b0, 1'b0);
        settle();
        chk("miss_gnt",   64'(bus.gnt_o), 64'b10);
        chk("miss_req",   64'(bus.lsu_mmu__req_o), 64'd1);
        chk("miss_vaddr", bus.lsu_mmu__vaddr_o, 64'h9000_2000);
        chk("miss_hit",   64'(bus.hit_o), 64'd0);
        adv();
        for (int k = 1; k <= 5; k++) begin
            drive(2'b11, 1'b0, (k == 5), 1'b0);
            settle();
            chk("lock_vaddr", bus.lsu_mmu__vaddr_o, 64'h9000_2000);
            chk("lock_gnt",   64'(bus.gnt_o), 64'b10);
            chk("lock_vld",   64'(bus.valid_o), (k == 5) ? 64'b10 : 64'b00);
            adv();
        end
        drive(2'b11, 1'b1, 1'b0, 1'b0);
        bus.vaddr_i[1] = 64'h0;
        settle();
        chk("after_gnt",   64'(bus.gnt_o), 64'b01);
        chk("after_vaddr", bus.lsu_mmu__vaddr_o, 64'h8000_1000);
        chk("after_hit",   64'(bus.hit_o), 64'b01);
        adv();

        // flush in BUSY together with valid
        drive(2'b01, 1'b0, 1'b0, 1'b0);
        settle();
        adv();
        drive(2'b01, 1'b0, 1'b1, 1'b1);
        settle();
        chk("flush_vld", 64'(bus.valid_o), 64'd0);
        chk("flush_gnt", 64'(bus.gnt_o), 64'd0);
        chk("flush_req", 64'(bus.lsu_mmu__req_o), 64'd0);
        adv();
        drive(2'b01, 1'b1, 1'b0, 1'b0);
        settle();
        chk("flush_idle_hit", 64'(bus.hit_o), 64'b01);
        adv();

        // stale response while idle
        drive(2'b00, 1'b0, 1'b1, 1'b0);
        settle();
        chk("stale_vld", 64'(bus.valid_o), 64'd0);
        chk("stale_gnt", 64'(bus.gnt_o), 64'd0);
        adv();

        // owner drops its request mid-walk; a late valid is dropped
        drive(2'b10, 1'b0, 1'b0, 1'b0);
        settle();
        adv();
        drive(2'b00, 1'b0, 1'b0, 1'b0);
        settle();
        chk("abort_req", 64'(bus.lsu_mmu__req_o), 64'd0);
        adv();
        drive(2'b00, 1'b0, 1'b1, 1'b0);
        settle();
        chk("abort_late_vld", 64'(bus.valid_o), 64'd0);
        adv();

        // async reset mid-walk
        drive(2'b01, 1'b0, 1'b0, 1'b0);
        settle();
        adv();
        #1;
        rst = 1'b1;
        #1;
        chk("arst_gnt", 64'(bus.gnt_o), 64'd0);
        chk("arst_req", 64'(bus.lsu_mmu__req_o), 64'd0);
        adv();
        rst = 1'b0;
        drive(2'b01, 1'b1, 1'b0, 1'b0);
        settle();
        chk("arst_idle_hit", 64'(bus.hit_o), 64'b01);
        adv();
        drive(2'b00, 1'b0, 1'b0, 1'b0);
        adv();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
